// File: rtl/guess_input_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : guess_input_if
//  Purpose  : Guess bus between the PS/2 guess front end and the
//             guess-tracking stage.
//  Signals  : guessed[25:0] - letters already guessed (bit i = letter i)
//             enable        - guesses are accepted only while high
//             load          - one-cycle strobe for a fresh, accepted guess
//             load_x[4:0]   - letter index of the guess, 0=A .. 25=Z
//             repeat_key    - one-cycle pulse for an already-guessed letter
//             frame_err     - one-cycle pulse on a bad or timed-out frame
//  Modports : master - the front end (drives the strobes)
//             slave  - the tracking stage (drives guessed/enable)
//  Revision : 1.0 - initial release
// ============================================================================
interface guess_input_if;
    logic [25:0] guessed;
    logic        enable;
    logic        load;
    logic [4:0]  load_x;
    logic        repeat_key;
    logic        frame_err;

    modport master (
        input  guessed,
        input  enable,
        output load,
        output load_x,
        output repeat_key,
        output frame_err
    );

    modport slave (
        output guessed,
        output enable,
        input  load,
        input  load_x,
        input  repeat_key,
        input  frame_err
    );
endinterface
`default_nettype wire

// File: rtl/guess_input.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : guess_input
//  Purpose  : Receives PS/2 keyboard frames, decodes letter make codes A-Z
//             and issues a single-cycle load strobe carrying the letter
//             index. Releases, extended keys, typematic repeats and letters
//             already guessed never produce a load.
//  Ports    : clk      - system clock
//             reset    - synchronous, active-high reset
//             ps2_clk  - raw PS/2 clock (asynchronous)
//             ps2_data - raw PS/2 data (asynchronous)
//             gi       - guess bus (master side): guessed/enable in,
//                        load/load_x/repeat_key/frame_err out
//  Params   : FILTER_LEN     - equal synchronized samples needed before the
//                              filtered PS/2 clock changes level
//             TIMEOUT_CYCLES - idle clk cycles that abort a partial frame
//  Revision : 1.0 - initial release
// ============================================================================
module guess_input #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic     clk,
    input  wire logic     reset,
    input  wire logic     ps2_clk,
    input  wire logic     ps2_data,
    guess_input_if.master gi
);

    localparam int c_fcnt_w = $clog2(FILTER_LEN) + 1;
    localparam int c_to_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_fcnt_w-1:0] c_filt_last = c_fcnt_w'(FILTER_LEN - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_t;

    rx_state_t r_state;
    rx_state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Synchronizers; both lines idle high, so they reset high.
    // ------------------------------------------------------------------
    logic r_clk_meta, r_clk_sync, r_data_meta, r_data_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    // ------------------------------------------------------------------
    // Clock glitch filter: count consecutive samples that differ from the
    // filtered level; flip on the FILTER_LEN-th one.
    // ------------------------------------------------------------------
    logic                r_filt_clk;
    logic [c_fcnt_w-1:0] r_filt_cnt;
    logic                w_filt_flip;
    logic                w_sample;

    assign w_filt_flip = (r_clk_sync != r_filt_clk) && (r_filt_cnt == c_filt_last);
    assign w_sample    = w_filt_flip && r_filt_clk;   // filtered 1->0

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_sync == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_filt_clk <= ~r_filt_clk;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame timeout
    // ------------------------------------------------------------------
    logic [c_to_w-1:0] r_to_cnt;
    logic              w_timeout;

    assign w_timeout = (r_state != S_IDLE) && !w_sample && (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (reset || r_state == S_IDLE || w_sample) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_parity;
    logic       w_frame_done;
    logic       w_frame_good;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        w_frame_good = 1'b0;
        case (r_state)
            S_IDLE:   if (w_sample && !r_data_sync) w_state_nxt = S_DATA;
            S_DATA:   if (w_sample && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (w_sample) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_sample) begin
                    w_state_nxt  = S_IDLE;
                    w_frame_done = 1'b1;
                    // Odd parity over data + parity, and stop bit high.
                    w_frame_good = r_data_sync && (^{r_shift, r_parity});
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) w_state_nxt = S_IDLE;
    end

    logic       r_byte_valid;
    logic [7:0] r_byte;
    logic       r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_sample) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {r_data_sync, r_shift[7:1]};  // LSB first
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    S_PARITY: r_parity <= r_data_sync;
                    default:  ;
                endcase
            end
            r_byte_valid <= w_frame_good;
            if (w_frame_good) r_byte <= r_shift;
            r_frame_err  <= (w_frame_done && !w_frame_good) || w_timeout;
        end
    end

    // ------------------------------------------------------------------
    // Make-code lookup
    // ------------------------------------------------------------------
    logic       w_is_letter;
    logic [4:0] w_letter_idx;

    always_comb begin
        w_is_letter  = 1'b1;
        w_letter_idx = 5'd0;
        case (r_byte)
            8'h1C: w_letter_idx = 5'd0;
            8'h32: w_letter_idx = 5'd1;
            8'h21: w_letter_idx = 5'd2;
            8'h23: w_letter_idx = 5'd3;
            8'h24: w_letter_idx = 5'd4;
            8'h2B: w_letter_idx = 5'd5;
            8'h34: w_letter_idx = 5'd6;
            8'h33: w_letter_idx = 5'd7;
            8'h43: w_letter_idx = 5'd8;
            8'h3B: w_letter_idx = 5'd9;
            8'h42: w_letter_idx = 5'd10;
            8'h4B: w_letter_idx = 5'd11;
            8'h3A: w_letter_idx = 5'd12;
            8'h31: w_letter_idx = 5'd13;
            8'h44: w_letter_idx = 5'd14;
            8'h4D: w_letter_idx = 5'd15;
            8'h15: w_letter_idx = 5'd16;
            8'h2D: w_letter_idx = 5'd17;
            8'h1B: w_letter_idx = 5'd18;
            8'h2C: w_letter_idx = 5'd19;
            8'h3C: w_letter_idx = 5'd20;
            8'h2A: w_letter_idx = 5'd21;
            8'h1D: w_letter_idx = 5'd22;
            8'h22: w_letter_idx = 5'd23;
            8'h35: w_letter_idx = 5'd24;
            8'h1A: w_letter_idx = 5'd25;
            default: w_is_letter = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Decoder flags, typematic filter and acceptance
    // ------------------------------------------------------------------
    logic       r_brk, r_ext;
    logic       r_held_valid;
    logic [4:0] r_held_idx;
    logic       r_load, r_repeat;
    logic [4:0] r_load_x;
    logic       w_held_match;

    assign w_held_match = w_is_letter && r_held_valid && (r_held_idx == w_letter_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
            r_held_valid <= 1'b0;
            r_held_idx   <= '0;
            r_load       <= 1'b0;
            r_repeat     <= 1'b0;
            r_load_x     <= '0;
        end else begin
            r_load   <= 1'b0;
            r_repeat <= 1'b0;
            if (r_byte_valid) begin
                if (r_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_ext) begin
                    // Extended key (make or break): swallow entirely.
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else if (r_brk) begin
                    r_brk <= 1'b0;
                    if (w_held_match) r_held_valid <= 1'b0;
                end else if (w_is_letter && !w_held_match) begin
                    // Held tracks the key physically down, whether or not
                    // guesses are currently enabled.
                    r_held_valid <= 1'b1;
                    r_held_idx   <= w_letter_idx;
                    if (gi.enable) begin
                        if (gi.guessed[w_letter_idx]) begin
                            r_repeat <= 1'b1;
                        end else begin
                            r_load   <= 1'b1;
                            r_load_x <= w_letter_idx;
                        end
                    end
                end
            end
        end
    end

    assign gi.load       = r_load;
    assign gi.load_x     = r_load_x;
    assign gi.repeat_key = r_repeat;
    assign gi.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_guess_input.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_guess_input
//  Purpose  : Directed self-checking bench for guess_input. Drives PS/2
//             frames bit by bit and checks load/repeat_key/frame_err pulse
//             counts, load_x values and stop-bit-to-load latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_guess_input;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 10;   // PS/2 half bit period in clk cycles
    // Drive-to-observe: 2 sync flops + FILTER_LEN filter samples give the
    // sample event, then byte_valid and load each add one register.
    localparam int LATENCY        = 2 + FILTER_LEN + 1;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk;
    logic ps2_data;

    guess_input_if gi ();

    guess_input #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .gi       (gi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output pulse monitor, sampled on the falling edge.
    int         n_load = 0;
    int         n_rep  = 0;
    int         n_err  = 0;
    int         last_load_cyc = 0;
    logic [4:0] last_x = '0;

    always @(negedge clk) begin
        if (gi.load === 1'b1) begin
            n_load        <= n_load + 1;
            last_x        <= gi.load_x;
            last_load_cyc <= cyc;
        end
        if (gi.repeat_key === 1'b1) n_rep <= n_rep + 1;
        if (gi.frame_err === 1'b1)  n_err <= n_err + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    int stop_cyc = 0;
    int l0, r0, e0;

    task automatic snap();
        @(negedge clk);
        l0 = n_load;
        r0 = n_rep;
        e0 = n_err;
    endtask

    // bits[0] goes out first; stop_cyc records the last falling edge drive.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b0;
            stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        logic par;
        par = (~^b) ^ flip;
        send_bits({1'b1, par, b, 1'b0}, 11);
        repeat (30) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        gi.guessed = '0;
        gi.enable  = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_load",   {31'd0, gi.load},       32'd0);
        check("rst_load_x", {27'd0, gi.load_x},     32'd0);
        check("rst_repeat", {31'd0, gi.repeat_key}, 32'd0);
        check("rst_err",    {31'd0, gi.frame_err},  32'd0);

        // 1: basic A, latency, release clears held
        snap();
        send(8'h1C);
        check("t1_load",    n_load - l0, 1);
        check("t1_x",       {27'd0, last_x}, 0);
        check("t1_latency", last_load_cyc - stop_cyc, LATENCY);
        snap();
        send(8'hF0); send(8'h1C);
        check("t1_rel_noload", n_load - l0, 0);
        snap();
        send(8'h1C);
        check("t1_held_clr", n_load - l0, 1);
        send(8'hF0); send(8'h1C);

        // 2: parity error then good Z
        snap();
        send_frame(8'h1A, 1'b1);
        check("t2_err",    n_err - e0, 1);
        check("t2_noload", n_load - l0, 0);
        snap();
        send(8'h1A);
        check("t2_load", n_load - l0, 1);
        check("t2_x",    {27'd0, last_x}, 25);
        send(8'hF0); send(8'h1A);

        // 3: already-guessed E
        gi.guessed = 26'd1 << 4;
        snap();
        send(8'h24);
        check("t3_repeat", n_rep - r0, 1);
        check("t3_noload", n_load - l0, 0);
        check("t3_x_hold", {27'd0, gi.load_x}, 25);
        send(8'hF0); send(8'h24);
        gi.guessed = '0;

        // 4: typematic
        snap();
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("t4_once", n_load - l0, 1);
        check("t4_x",    {27'd0, last_x}, 0);
        snap();
        send(8'hF0); send(8'h1C); send(8'h1C);
        check("t4_again", n_load - l0, 1);
        send(8'hF0); send(8'h1C);

        // 5: extended, non-letter, enable gating
        snap();
        send(8'hE0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h1C);
        send(8'h29);
        check("t5_ext_load", n_load - l0, 0);
        check("t5_ext_rep",  n_rep - r0, 0);
        check("t5_ext_err",  n_err - e0, 0);
        gi.enable = 1'b0;
        snap();
        send(8'h32);
        check("t5_dis_load", n_load - l0, 0);
        check("t5_dis_rep",  n_rep - r0, 0);
        send(8'hF0); send(8'h32);
        gi.enable = 1'b1;
        snap();
        send(8'h32);
        check("t5_en_load", n_load - l0, 1);
        check("t5_en_x",    {27'd0, last_x}, 1);
        send(8'hF0); send(8'h32);

        // 6: timeout, then good Q; reset mid-frame, then good W
        snap();
        send_bits(11'b000_0001_0110, 5);
        repeat (TIMEOUT_CYCLES + 50) @(negedge clk);
        check("t6_to_err",    n_err - e0, 1);
        check("t6_to_noload", n_load - l0, 0);
        snap();
        send(8'h15);
        check("t6_q_load", n_load - l0, 1);
        check("t6_q_x",    {27'd0, last_x}, 16);
        snap();
        send_bits(11'b000_0001_1010, 5);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_x", {27'd0, gi.load_x}, 0);
        repeat (TIMEOUT_CYCLES + 50) @(negedge clk);
        check("t6_rst_err",  n_err - e0, 0);
        check("t6_rst_load", n_load - l0, 0);
        check("t6_rst_rep",  n_rep - r0, 0);
        snap();
        send(8'h1D);
        check("t6_w_load", n_load - l0, 1);
        check("t6_w_x",    {27'd0, last_x}, 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
